// File: rtl/psram_emu_responder_if.sv
// Request/response bundle between a PSRAM requester (mapper FSM) and the responder.
// The err signal only exists when PSRAM_EMU_ERR_EN is defined.
interface psram_emu_responder_if;
    logic        read;
    logic        write;
    logic [21:0] addr;
    logic [15:0] din;
    logic        byte_write;
    logic [15:0] dout;
    logic        busy;
`ifdef PSRAM_EMU_ERR_EN
    logic        err;
`endif

`ifdef PSRAM_EMU_ERR_EN
    modport master (output read, write, addr, din, byte_write, input dout, busy, err);
    modport slave  (input read, write, addr, din, byte_write, output dout, busy, err);
`else
    modport master (output read, write, addr, din, byte_write, input dout, busy);
    modport slave  (input read, write, addr, din, byte_write, output dout, busy);
`endif
endinterface

// File: rtl/psram_emu_responder.sv
// Block-RAM stand-in for the PSRAM controller user side: init delay, fixed latency, byte lanes.
// Optional sticky protocol-error flag enabled by defining PSRAM_EMU_ERR_EN.

// One 8-bit byte lane of backing store; no reset so it maps onto BSRAM.
module psram_emu_lane #(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        rdata <= mem[idx];
    end
endmodule

module psram_emu_responder #(
    parameter int MEM_AW      = 13,
    parameter int INIT_CYCLES = 64,
    parameter int LAT_CYCLES  = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    psram_emu_responder_if.slave  bus
);
    localparam int NUM_LANES = 2;
    localparam int CNT_MAX   = (INIT_CYCLES > LAT_CYCLES) ? INIT_CYCLES : LAT_CYCLES;
    localparam int CW        = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WR_WAIT, S_RD_WAIT} state_t;

    state_t                       state;
    logic [CW-1:0]                cnt;
    logic                         busy_q;
    logic [15:0]                  dout_q;
    logic [MEM_AW-1:0]            idx_q;
    logic                         lane_sel_q;
    logic                         bw_q;
    logic [NUM_LANES-1:0][7:0]    wdata_q;
    logic [NUM_LANES-1:0][7:0]    rdata;
    logic [NUM_LANES-1:0]         lane_we;
    logic                         wr_fire;
    logic                         unused_addr_hi;

    // Addresses above the backing RAM simply alias.
    assign unused_addr_hi = ^bus.addr[21:MEM_AW+1];

    // The RAM write lands on the first cycle after acceptance.
    assign wr_fire = (state == S_WR_WAIT) && (cnt == CW'(LAT_CYCLES - 1));

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign lane_we[g] = wr_fire & (~bw_q | (lane_sel_q == 1'(g)));
        psram_emu_lane #(.AW(MEM_AW)) u_lane (
            .clk   (clk),
            .we    (lane_we[g]),
            .idx   (idx_q),
            .wdata (wdata_q[g]),
            .rdata (rdata[g])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_INIT;
            cnt        <= CW'(INIT_CYCLES - 1);
            busy_q     <= 1'b1;
            dout_q     <= '0;
            idx_q      <= '0;
            lane_sel_q <= 1'b0;
            bw_q       <= 1'b0;
            wdata_q    <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    if (cnt == '0) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else cnt <= cnt - 1'b1;
                end
                S_IDLE: begin
                    if (bus.write | bus.read) begin
                        state      <= bus.write ? S_WR_WAIT : S_RD_WAIT;
                        busy_q     <= 1'b1;
                        cnt        <= CW'(LAT_CYCLES - 1);
                        idx_q      <= bus.addr[MEM_AW:1];
                        lane_sel_q <= bus.addr[0];
                        bw_q       <= bus.byte_write;
                        wdata_q    <= bus.din;
                    end
                end
                S_WR_WAIT: begin
                    if (cnt == '0) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else cnt <= cnt - 1'b1;
                end
                S_RD_WAIT: begin
                    // rdata has been tracking idx_q since the cycle after acceptance.
                    if (cnt == '0) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        dout_q <= rdata;
                    end else cnt <= cnt - 1'b1;
                end
                default: state <= S_INIT;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.dout = dout_q;

`ifdef PSRAM_EMU_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) err_q <= 1'b0;
        else if ((busy_q && (state != S_INIT) && (bus.read | bus.write)) ||
                 (bus.read && bus.write))
            err_q <= 1'b1;
    end

    assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_psram_emu_responder.sv
// Randomized scoreboard bench for psram_emu_responder against a word-array reference model.
module tb_psram_emu_responder;
    localparam int MEM_AW      = 13;
    localparam int INIT_CYCLES = 64;
    localparam int LAT_CYCLES  = 6;

    typedef struct {
        string       name;
        logic [15:0] dout;
        int          len;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    psram_emu_responder_if bus();

    psram_emu_responder #(
        .MEM_AW(MEM_AW), .INIT_CYCLES(INIT_CYCLES), .LAT_CYCLES(LAT_CYCLES)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    logic [15:0] model_mem [int];
    logic [15:0] last_dout;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int word_idx(input logic [21:0] a);
        return int'(a / 2) % (1 << MEM_AW);
    endfunction

    // Busy periods are measured here, decoupled from stimulus; each fall pops one expectation.
    initial begin
        int   run = 0;
        logic pb  = 1'b1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                run = 0;
                pb  = 1'b1;
            end else begin
                if (bus.busy) run++;
                else if (pb) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_busy_period: len %0d, no expectation queued", run);
                    end else begin
                        e = q.pop_front();
                        check({e.name, "_busy_len"}, 32'(run), 32'(e.len));
                        check({e.name, "_dout"}, {16'h0, bus.dout}, {16'h0, e.dout});
                    end
                    run = 0;
                end
                pb = bus.busy;
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (bus.busy && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (bus.busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle_timeout: busy still %0b after %0d cycles", bus.busy, t);
        end
    endtask

    // Drive one request pulse and record what the reference model says must come back.
    task automatic issue(input string nm, input bit rd, input bit wr,
                         input logic [21:0] a, input logic [15:0] d, input bit bw);
        exp_t        e;
        logic [15:0] w;
        int          i;
        wait_idle();
        bus.read = rd; bus.write = wr; bus.addr = a; bus.din = d; bus.byte_write = bw;
        i = word_idx(a);
        if (wr) begin
            w = model_mem.exists(i) ? model_mem[i] : 16'h0;
            if (!bw)      w = d;
            else if (a[0]) w[15:8] = d[15:8];
            else          w[7:0]  = d[7:0];
            model_mem[i] = w;
        end else if (rd) begin
            last_dout = model_mem[i];
        end
        e.name = nm; e.dout = last_dout; e.len = LAT_CYCLES;
        q.push_back(e);
        @(posedge clk); #1;
        bus.read = 1'b0; bus.write = 1'b0;
    endtask

    task automatic push_init();
        exp_t e;
        e.name = "init"; e.dout = 16'h0; e.len = INIT_CYCLES;
        last_dout = 16'h0;
        q.push_back(e);
    endtask

    initial begin
        logic [12:0] pool [8] = '{13'd8, 13'd1, 13'd2, 13'd100, 13'd8191, 13'd4000, 13'd77, 13'd3};
        bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.din = '0; bus.byte_write = 1'b0;
        last_dout = 16'h0;

        // Reset and power-up delay; requests during INIT must be ignored.
        push_init();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus.read = 1'b1;
        @(posedge clk); #1 bus.read = 1'b0;

        // Basic write/read, byte lanes, aliasing.
        issue("wr_a55a", 0, 1, 22'h000010, 16'hA55A, 0);
        issue("rd_a55a", 1, 0, 22'h000010, 16'h0, 0);
        issue("wr_1234", 0, 1, 22'h000010, 16'h1234, 0);
        issue("bw_hi",   0, 1, 22'h000011, 16'hCD00, 1);
        issue("bw_lo",   0, 1, 22'h000010, 16'h00EF, 1);
        issue("rd_cdef", 1, 0, 22'h000010, 16'h0, 0);
        issue("wr_beef", 0, 1, 22'h004002, 16'hBEEF, 0);
        issue("rd_alias", 1, 0, 22'h000002, 16'h0, 0);

        // Simultaneous read+write: write wins; a read during busy is ignored.
        issue("rw_both", 1, 1, 22'h000020, 16'h7777, 0);
        bus.read = 1'b1;
        @(posedge clk); #1 bus.read = 1'b0;
`ifdef PSRAM_EMU_ERR_EN
        check("err_set", {31'h0, bus.err}, 32'h1);
`endif
        issue("rd_7777", 1, 0, 22'h000020, 16'h0, 0);
`ifdef PSRAM_EMU_ERR_EN
        check("err_sticky", {31'h0, bus.err}, 32'h1);
`endif

        // Randomized traffic over a small pool of words with random alias bits.
        foreach (pool[k]) issue("rnd_init", 0, 1, {8'h00, pool[k], 1'b0}, 16'($urandom), 0);
        for (int n = 0; n < 40; n++) begin
            logic [7:0]  hi;
            logic [12:0] w;
            logic        ln;
            int          op;
            hi = 8'($urandom_range(0, 255));
            w  = pool[$urandom_range(0, 7)];
            ln = 1'($urandom_range(0, 1));
            op = $urandom_range(0, 2);
            if (op == 0)      issue("rnd_rd", 1, 0, {hi, w, ln}, 16'h0, 0);
            else if (op == 1) issue("rnd_wr", 0, 1, {hi, w, ln}, 16'($urandom), 0);
            else              issue("rnd_bw", 0, 1, {hi, w, ln}, 16'($urandom), 1);
        end

        // Reset in the middle of a read: aborted, INIT repeats, RAM contents survive.
        issue("rd_abort", 1, 0, 22'h000010, 16'h0, 0);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        check("mid_reset_busy", {31'h0, bus.busy}, 32'h1);
        check("mid_reset_dout", {16'h0, bus.dout}, 32'h0);
`ifdef PSRAM_EMU_ERR_EN
        check("mid_reset_err", {31'h0, bus.err}, 32'h0);
`endif
        q.delete();
        push_init();
        @(posedge clk); #1 resetn = 1'b1;
        issue("rd_after_reset", 1, 0, 22'h000010, 16'h0, 0);
        issue("rd_alias_after_reset", 1, 0, 22'h000002, 16'h0, 0);

        begin
            int t = 0;
            while (q.size() != 0 && t < 5000) begin
                @(negedge clk);
                t++;
            end
            if (q.size() != 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain_timeout: %0d expectations left, expected 0", q.size());
            end
        end
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
